// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the baud generator.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line plus a tick-paced
// previous-sample flop used to find the falling edge of a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  input  logic rx_enb,
  output logic rx_s,
  output logic fall
);

  logic sync1_r;
  logic sync2_r;
  logic rx_prev_r;

  // Synchroniser chain and oversample-rate history; all reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
      if (rx_enb) begin
        rx_prev_r <= sync2_r;
      end else begin
        rx_prev_r <= rx_prev_r;
      end
    end
  end

  assign rx_s = sync2_r;
  // Qualified by rx_enb in the consumer; a level held low never looks like an edge.
  assign fall = rx_prev_r & ~sync2_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start detection, mid-bit sampling,
// registered done and frame-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_enb,
  output logic [DATA_BITS-1:0] doutrx,
  output logic                 donerx,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  logic                 fall_s;

  rx_state_t            state_r;
  rx_state_t            state_nxt;
  logic [TICK_W-1:0]    tick_cnt_r;
  logic [TICK_W-1:0]    tick_nxt;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [BIT_W-1:0]     bit_nxt;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] doutrx_r;
  logic [DATA_BITS-1:0] dout_nxt;
  logic                 donerx_r;
  logic                 done_nxt;
  logic                 frame_err_r;
  logic                 ferr_nxt;
  logic                 busy_r;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_enb (rx_enb),
    .rx_s   (rx_s),
    .fall   (fall_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= RX_IDLE;
      tick_cnt_r  <= {TICK_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      shift_r     <= {DATA_BITS{1'b0}};
      doutrx_r    <= {DATA_BITS{1'b0}};
      donerx_r    <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      tick_cnt_r  <= tick_nxt;
      bit_cnt_r   <= bit_nxt;
      shift_r     <= shift_nxt;
      doutrx_r    <= dout_nxt;
      donerx_r    <= done_nxt;
      frame_err_r <= ferr_nxt;
      busy_r      <= (state_nxt != RX_IDLE);
    end
  end

  // Next-state and datapath decode; nothing moves except on an rx_enb tick.
  always_comb begin
    state_nxt = state_r;
    tick_nxt  = tick_cnt_r;
    bit_nxt   = bit_cnt_r;
    shift_nxt = shift_r;
    dout_nxt  = doutrx_r;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    if (rx_enb) begin
      case (state_r)
        RX_IDLE: begin
          if (fall_s) begin
            state_nxt = RX_START;
            tick_nxt  = {TICK_W{1'b0}};
          end else begin
            state_nxt = RX_IDLE;
          end
        end
        RX_START: begin
          if (tick_cnt_r == HALF_LAST) begin
            tick_nxt = {TICK_W{1'b0}};
            bit_nxt  = {BIT_W{1'b0}};
            if (!rx_s) begin
              state_nxt = RX_DATA;
            end else begin
              state_nxt = RX_IDLE;
            end
          end else begin
            tick_nxt = tick_cnt_r + TICK_W'(1);
          end
        end
        RX_DATA: begin
          if (tick_cnt_r == BIT_LAST) begin
            tick_nxt  = {TICK_W{1'b0}};
            shift_nxt = {rx_s, shift_r[DATA_BITS-1:1]};
            bit_nxt   = bit_cnt_r + BIT_W'(1);
            if (bit_cnt_r == DATA_LAST) begin
              state_nxt = RX_STOP;
            end else begin
              state_nxt = RX_DATA;
            end
          end else begin
            tick_nxt = tick_cnt_r + TICK_W'(1);
          end
        end
        RX_STOP: begin
          if (tick_cnt_r == BIT_LAST) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            tick_nxt  = {TICK_W{1'b0}};
            state_nxt = RX_IDLE;
            if (rx_s) begin
              dout_nxt = shift_r;
              done_nxt = 1'b1;
            end else begin
              ferr_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt_r + TICK_W'(1);
          end
        end
        default: begin
          state_nxt = RX_IDLE;
          tick_nxt  = {TICK_W{1'b0}};
          bit_nxt   = {BIT_W{1'b0}};
        end
      endcase
    end else begin
      state_nxt = state_r;
    end
  end

  assign doutrx    = doutrx_r;
  assign donerx    = donerx_r;
  assign frame_err = frame_err_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// scored against a queue of expected frame outcomes.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_enb = 1'b1;
  logic [7:0] doutrx;
  logic       donerx;
  logic       frame_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_enb    (rx_enb),
    .doutrx    (doutrx),
    .donerx    (donerx),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mon_exp;
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_pass = 0;
  int         n_done = 0;
  int         n_err = 0;
  int         exp_done = 0;
  int         exp_err = 0;
  int         busy_cnt = 0;
  int         div = 1;
  int         div_cnt = 0;
  logic       prev_pulse = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Oversample tick: one clk wide every div clks.
  always @(negedge clk) begin
    if (div_cnt >= div - 1) div_cnt = 0;
    else div_cnt++;
    rx_enb = (div_cnt == 0);
  end

  // Monitor: every pulse must match the oldest expected frame outcome.
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (donerx || frame_err) begin
      check("pulse_excl", {31'd0, donerx & frame_err}, 32'd0);
      check("pulse_width", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, donerx, frame_err}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.is_err ? "kind_err" : "kind_done", {31'd0, frame_err}, {31'd0, mon_e.is_err});
        mon_exp = mon_e.is_err ? last_good : mon_e.data;
        check("doutrx_at_pulse", {24'd0, doutrx}, {24'd0, mon_exp});
        if (!mon_e.is_err) last_good = mon_e.data;
      end
      if (donerx) n_done++;
      else n_err++;
    end
    prev_pulse = donerx | frame_err;
  end

  task automatic send_bit(input logic v);
    rx = v;
    repeat (OS * div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop);
    exp_t e;
    e.is_err = !stop;
    e.data   = d;
    exp_q.push_back(e);
    if (stop) exp_done++;
    else exp_err++;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    exp_q.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         d0;
    logic [7:0] rd;
    bit         rs;
    int         wait_n;

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_doutrx", {24'd0, doutrx}, 32'd0);
    check("reset_donerx", {31'd0, donerx}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    busy_cnt = 0;
    idle(100);
    check("idle_busy", busy_cnt, 32'd0);
    check("idle_doutrx", {24'd0, doutrx}, 32'd0);
    check("idle_pulses", n_done + n_err, 32'd0);

    // Single frame, full-rate ticks then every 4th clk.
    send_frame(8'hA5, 1'b1);
    idle(20);
    check("a5_done_count", n_done, 32'd1);
    check("a5_doutrx", {24'd0, doutrx}, 32'h A5);
    check("a5_err_count", n_err, 32'd0);
    div = 4;
    send_frame(8'hA5, 1'b1);
    idle(80);
    div = 1;
    check("a5_div4_done_count", n_done, 32'd2);
    check("a5_div4_doutrx", {24'd0, doutrx}, 32'h A5);

    // Back-to-back frames with no idle gap.
    d0 = n_done;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(20);
    check("b2b_done_count", n_done - d0, 32'd2);
    check("b2b_doutrx", {24'd0, doutrx}, 32'h FF);

    // Bad stop bit, line then held low: no re-arm until it goes high.
    d0 = n_err;
    send_frame(8'h3C, 1'b0);
    busy_cnt = 0;
    repeat (40) @(negedge clk);
    check("badstop_busy_low", busy_cnt, 32'd0);
    check("badstop_err_count", n_err - d0, 32'd1);
    check("badstop_doutrx_kept", {24'd0, doutrx}, 32'h FF);
    idle(40);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("rearm_doutrx", {24'd0, doutrx}, 32'h 3C);

    // Short glitch is rejected at mid start bit.
    d0 = n_done + n_err;
    busy_cnt = 0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check("glitch_busy_bounded", {31'd0, (busy_cnt >= 1 && busy_cnt <= 8)}, 32'd1);
    check("glitch_no_pulse", n_done + n_err - d0, 32'd0);

    // Reset during data bit 3 of 0x5A abandons the frame.
    rd = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(rd[i]);
    rx = rd[3];
    repeat (8) @(negedge clk);
    d0 = n_done + n_err;
    do_reset(1);
    idle(40);
    check("midrst_doutrx", {24'd0, doutrx}, 32'd0);
    check("midrst_no_pulse", n_done + n_err - d0, 32'd0);
    d0 = n_done;
    send_frame(8'h81, 1'b1);
    idle(20);
    check("midrst_done_count", n_done - d0, 32'd1);
    check("midrst_doutrx_81", {24'd0, doutrx}, 32'h 81);

    // Randomized frames at mixed tick rates and gaps.
    n_done   = 0;
    n_err    = 0;
    exp_done = 0;
    exp_err  = 0;
    for (int k = 0; k < 20; k++) begin
      div = $urandom_range(1, 3);
      rd  = 8'($urandom);
      rs  = ($urandom_range(0, 4) != 0);
      send_frame(rd, rs);
      if (!rs) idle(OS * div);
      else idle($urandom_range(0, 20));
    end
    div = 1;
    idle(40);
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 2000) begin
      @(negedge clk);
      wait_n++;
    end
    check("rand_drain", exp_q.size(), 32'd0);
    check("rand_done_total", n_done, exp_done);
    check("rand_err_total", n_err, exp_err);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
